link_word_packer: RTL

- Downstream consumer of the off-chip link receive stage.
- Takes the link's reassembled byte stream (data_out/valid_out), drives the link's ready, and packs consecutive byte pairs into 16-bit words, first byte in the low half.
- Buffers the words in a small FIFO and presents them to the on-chip sink over a valid/ready handshake.
- A flush input forces out a pending odd byte as a zero-padded partial word.

---
 rtl/link_pkg.sv | 24 ++
 rtl/link_word_fifo.sv | 60 ++++++
 rtl/link_word_packer.sv | 111 +++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// Shared link constants and the word-FIFO entry layout.
// The link receive stage's checker uses these same constants.
package link_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h00;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              partial;
  } fifo_entry_t;

  // The first byte received goes in the low half of the word.
  function automatic fifo_entry_t make_entry(input logic [BYTE_W-1:0] hi,
                                             input logic [BYTE_W-1:0] lo,
                                             input logic              partial);
    fifo_entry_t e;
    e.data    = {hi, lo};
    e.partial = partial;
    return e;
  endfunction

endpackage

// File: rtl/link_word_fifo.sv
// Small synchronous word FIFO. It has no full-bypass: a push is honoured only when there is free space.
// The head entry is read combinationally.
module link_word_fifo
  import link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  fifo_entry_t                push_entry_i,
  input  logic                       pop_i,
  output fifo_entry_t                head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fifo_entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]       wptr_q;
  logic [PTR_W-1:0]       rptr_q;
  logic [PTR_W:0]         count_q;
  logic                   push_ok;
  logic                   pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage is cleared on reset as well, so out_data reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= push_entry_i;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/link_word_packer.sv
// Packs link bytes in pairs into 16-bit words, with the first byte in the low half.
// It queues the words for the on-chip sink, and a flush emits any held odd byte padded with zero.
module link_word_packer
  import link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [WORD_W-1:0] out_data,
  output logic              out_partial,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [BYTE_W-1:0] hold_q, hold_d;
  logic              half_q, half_d;
  logic              flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  logic              push;
  fifo_entry_t       push_entry;
  logic              pop;
  logic              accept;
  fifo_entry_t       head;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;

  // A flush that hits a held byte takes the FIFO slot for this cycle, so the link is stalled.
  assign in_ready  = (count < (PTR_W+1)'(DEPTH)) && !flush_pend_q && !(flush && half_q);
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = head.data;
  assign out_partial = head.partial;
  assign word_cnt  = word_cnt_q;

  // A pending padded word outranks a new flush, and a new flush outranks a byte accept.
  // flush_pend only covers a flush that arrives while the FIFO is full.
  always_comb begin
    hold_d       = hold_q;
    half_d       = half_q;
    flush_pend_d = flush_pend_q;
    push         = 1'b0;
    push_entry   = '0;
    if (flush_pend_q) begin
      if (!full) begin
        push         = 1'b1;
        push_entry   = make_entry(PAD_BYTE, hold_q, 1'b1);
        flush_pend_d = 1'b0;
        half_d       = 1'b0;
      end
    end else if (flush && half_q) begin
      if (!full) begin
        push       = 1'b1;
        push_entry = make_entry(PAD_BYTE, hold_q, 1'b1);
        half_d     = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end else if (accept) begin
      if (half_q) begin
        push       = 1'b1;
        push_entry = make_entry(in_data, hold_q, 1'b0);
        half_d     = 1'b0;
      end else begin
        hold_d = in_data;
        half_d = 1'b1;
      end
    end
    word_cnt_d = word_cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      half_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      hold_q       <= hold_d;
      half_q       <= half_d;
      flush_pend_q <= flush_pend_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  link_word_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

endmodule
